// File: rtl/sprite_loader.sv
// sprite_loader: write-side companion to the sprite renderer.
// Accepts packed 1-bpp bitmap bytes over a valid/ready handshake and unpacks
// each byte MSB-first into single-pixel writes to the sprite bitmap RAM, in
// row-major order (address = y*SPR_WIDTH + x). A load always writes exactly
// SPR_WIDTH*SPR_HEIGHT pixels, starting at address 0.
//
// Optional feature macro: SPRITE_LOADER_VBLANK_GATE_EN
//   When defined, byte acceptance and pixel writes only happen while vblank=1.
//   UNPACK progress freezes while vblank=0, so the renderer never scans out a
//   half-updated bitmap. When undefined, vblank is ignored.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse, begins a load at address 0 (ignored while busy)
//   in_data   packed pixel byte, bit 7 is the first pixel
//   in_valid  in_data valid
//   in_ready  loader can accept a byte this cycle
//   vblank    vertical blanking indicator (used only with the gate macro)
//   we        RAM write enable
//   waddr     RAM write address
//   wdata     RAM write pixel
//   busy      high whenever the loader is not idle
//   done      one-cycle pulse after the last pixel has been written
module sprite_loader #(
  parameter int unsigned  SPR_WIDTH  = 8,
  parameter int unsigned  SPR_HEIGHT = 8,
  localparam int unsigned DEPTH      = SPR_WIDTH * SPR_HEIGHT,
  localparam int unsigned ADDRW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             vblank,
  output logic             we,
  output logic [ADDRW-1:0] waddr,
  output logic             wdata,
  output logic             busy,
  output logic             done
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;

  // Permission to make progress in LOAD/UNPACK this cycle.
  logic gate_c;
`ifdef SPRITE_LOADER_VBLANK_GATE_EN
  assign gate_c = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_c        = 1'b1;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      LOAD: begin
        if (in_valid && gate_c) begin
          shift_d  = in_data;
          bitcnt_d = 4'd8;
          state_d  = UNPACK;
        end
      end
      UNPACK: begin
        if (gate_c) begin
          shift_d  = {shift_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q - 4'd1;
          // Last pixel wins over end-of-byte; leftover bits are dropped and
          // addr stays at the final address instead of wrapping.
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDRW'(1);
            if (bitcnt_q == 4'd1) begin
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Outputs decode registered state only (plus vblank when gated).
  assign in_ready = (state_q == LOAD) && gate_c;
  assign we       = (state_q == UNPACK) && gate_c;
  assign waddr    = addr_q;
  assign wdata    = shift_q[7];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: an 8x8 instance and a 10x3 instance
// driven with fixed and $urandom byte streams. The reference is the pixel
// stream implied by the bytes (pixel p = bit 7-p%8 of byte p/8 at address p)
// together with handshake/done cycle numbers computed from the timing rules.
module tb_sprite_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblank;
  logic       start    [2];
  logic [7:0] in_data  [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic       we       [2];
  logic       wdata    [2];
  logic       busy     [2];
  logic       done     [2];
  logic [5:0] waddr0;
  logic [4:0] waddr1;

  always #5 clk = ~clk;

  sprite_loader #(.SPR_WIDTH(8), .SPR_HEIGHT(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .vblank(vblank),
    .we(we[0]), .waddr(waddr0), .wdata(wdata[0]), .busy(busy[0]), .done(done[0])
  );

  sprite_loader #(.SPR_WIDTH(10), .SPR_HEIGHT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .vblank(vblank),
    .we(we[1]), .waddr(waddr1), .wdata(wdata[1]), .busy(busy[1]), .done(done[1])
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         depth [2] = '{64, 30};
  logic [7:0] exp_bytes [2][8];
  int         acc_cyc   [2][8];
  int         nbytes    [2];
  int         acc_cnt   [2];
  int         wr_cnt    [2];
  int         done_cnt  [2];
  bit         lat_chk;
  bit         vb_low;
  int         poke_cyc;
  int         poke_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pixel(input int i, input int p);
    logic [7:0] b;
    b = exp_bytes[i][p / 8];
    return b[7 - (p % 8)];
  endfunction

  // Observe handshakes, writes and done pulses against the reference stream.
  task automatic sample();
    int p;
    int wa;
    for (int i = 0; i < 2; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        if (acc_cnt[i] >= nbytes[i]) check($sformatf("extra_accept%0d", i), acc_cnt[i] + 1, nbytes[i]);
        else acc_cyc[i][acc_cnt[i]] = cyc;
        acc_cnt[i]++;
      end
      if (we[i]) begin
        p  = wr_cnt[i];
        wa = (i == 0) ? int'(waddr0) : int'(waddr1);
        if (p >= depth[i]) begin
          check($sformatf("write_overrun%0d", i), p, depth[i] - 1);
        end else begin
          check($sformatf("waddr%0d", i), wa, p);
          check($sformatf("wdata%0d@%0d", i, p), wdata[i], pixel(i, p));
          if (lat_chk && (p / 8) < acc_cnt[i])
            check($sformatf("write_latency%0d@%0d", i, p), cyc - acc_cyc[i][p / 8], 1 + p % 8);
        end
        wr_cnt[i]++;
      end
      if (done[i]) done_cnt[i]++;
    end
  endtask

  // One clock: sample before the edge, then drive 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    if (cyc == poke_cyc) start[poke_sel] = 1'b1;
`ifdef SPRITE_LOADER_VBLANK_GATE_EN
    vblank = ~vb_low;
`else
    vblank = 1'($urandom);
`endif
  endtask

  task automatic clear_mon(input int i, input int nb);
    nbytes[i]   = nb;
    acc_cnt[i]  = 0;
    wr_cnt[i]   = 0;
    done_cnt[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_in_ready%0d", tag, i), in_ready[i], 0);
      check($sformatf("%s_we%0d", tag, i), we[i], 0);
      check($sformatf("%s_waddr%0d", tag, i), (i == 0) ? 32'(waddr0) : 32'(waddr1), 0);
      check($sformatf("%s_wdata%0d", tag, i), wdata[i], 0);
      check($sformatf("%s_busy%0d", tag, i), busy[i], 0);
      check($sformatf("%s_done%0d", tag, i), done[i], 0);
    end
  endtask

  // Full load of nb bytes; g = cycles in_valid stays low in each LOAD
  // (g=0 holds in_valid high throughout); extra = keep offering a byte after
  // the last one; vb_gap = hold vblank low for UNPACK cycles 3..10 of byte 0.
  task automatic run_load(input int sel, input int nb, input int g, input bit extra,
                          input bit vb_gap, output int s, output int dc);
    int bound;
    int pix_last;
    int gap_add;
    int exp_acc;
    clear_mon(sel, nb);
    check($sformatf("idle_busy%0d", sel), busy[sel], 0);
    s = cyc;
    start[sel]    = 1'b1;
    in_valid[sel] = 1'b0;
    tick();
    check($sformatf("start_busy%0d", sel), busy[sel], 1);
    check($sformatf("start_ready%0d", sel), in_ready[sel], 1);
    for (int k = 0; k < nb; k++) begin
      in_data[sel]  = exp_bytes[sel][k];
      in_valid[sel] = (g == 0);
      bound = 0;
      while (!in_ready[sel] && bound < 40) begin
        tick();
        bound++;
      end
      if (bound >= 40) begin
        check($sformatf("ready_timeout%0d", sel), 0, 1);
        break;
      end
      repeat (g) tick();
      in_valid[sel] = 1'b1;
      tick();
`ifdef SPRITE_LOADER_VBLANK_GATE_EN
      if (vb_gap && k == 0) begin
        tick();
        vb_low = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
          check("gap_we", we[0], 0);
          check("gap_waddr", waddr0, 2);
          if (j == 7) vb_low = 1'b0;
          tick();
        end
      end
`endif
    end
    in_valid[sel] = extra;
    in_data[sel]  = 8'hA5;
    bound = 0;
    while (!done[sel] && bound < 200) begin
      tick();
      bound++;
    end
    if (bound >= 200) check($sformatf("done_timeout%0d", sel), 0, 1);
    dc       = cyc;
    gap_add  = vb_gap ? 8 : 0;
    pix_last = depth[sel] - 8 * (nb - 1);
    check($sformatf("done_cycle%0d", sel), dc,
          s + 1 + g + (nb - 1) * (9 + g) + gap_add + pix_last + 1);
    tick();
    check($sformatf("post_busy%0d", sel), busy[sel], 0);
    check($sformatf("post_done%0d", sel), done[sel], 0);
    check($sformatf("post_ready%0d", sel), in_ready[sel], 0);
    repeat (3) tick();
    in_valid[sel] = 1'b0;
    tick();
    check($sformatf("accept_count%0d", sel), acc_cnt[sel], nb);
    check($sformatf("write_count%0d", sel), wr_cnt[sel], depth[sel]);
    check($sformatf("done_count%0d", sel), done_cnt[sel], 1);
    for (int k = 0; k < nb && k < acc_cnt[sel]; k++) begin
      exp_acc = s + 1 + g + k * (9 + g) + ((k > 0) ? gap_add : 0);
      check($sformatf("accept_cycle%0d_%0d", sel, k), acc_cyc[sel][k], exp_acc);
    end
  endtask

  task automatic fill_random(input int sel, input int nb);
    for (int k = 0; k < nb; k++) exp_bytes[sel][k] = 8'($urandom);
  endtask

  initial begin
    int s;
    int dc;
    int bound;
    logic [7:0] pat [8];
    pat = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    rst      = 1'b1;
    vblank   = 1'b1;
    vb_low   = 1'b0;
    lat_chk  = 1'b1;
    poke_cyc = -1;
    poke_sel = 0;
    for (int i = 0; i < 2; i++) begin
      start[i]    = 1'b0;
      in_data[i]  = 8'h00;
      in_valid[i] = 1'b0;
      clear_mon(i, 0);
    end
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Fixed X pattern, in_valid held high.
    for (int k = 0; k < 8; k++) exp_bytes[0][k] = pat[k];
    run_load(0, 8, 0, 1'b0, 1'b0, s, dc);
    check("load_cycles_incl", dc - s + 1, 74);

    // Same pattern, 3 idle cycles in every LOAD.
    run_load(0, 8, 3, 1'b0, 1'b0, s, dc);

    // 10x3: last byte partially used, a fifth byte is offered but refused.
    exp_bytes[1][0] = 8'hFF;
    exp_bytes[1][1] = 8'hFF;
    exp_bytes[1][2] = 8'hFF;
    exp_bytes[1][3] = 8'hFC;
    run_load(1, 4, 0, 1'b1, 1'b0, s, dc);

    // start pulsed again 20 cycles into an active load.
    fill_random(0, 8);
    poke_sel = 0;
    poke_cyc = cyc + 20;
    run_load(0, 8, 0, 1'b0, 1'b0, s, dc);
    poke_cyc = -1;

    // Reset while writing address 13, then a fresh load from address 0.
    fill_random(0, 8);
    clear_mon(0, 8);
    start[0] = 1'b1;
    tick();
    in_data[0]  = exp_bytes[0][0];
    in_valid[0] = 1'b1;
    tick();
    in_data[0] = exp_bytes[0][1];
    bound = 0;
    while (!in_ready[0] && bound < 40) begin
      tick();
      bound++;
    end
    if (bound >= 40) check("rst_ready_timeout", 0, 1);
    tick();
    repeat (5) tick();
    check("pre_rst_we", we[0], 1);
    check("pre_rst_waddr", waddr0, 13);
    rst         = 1'b1;
    in_valid[0] = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_writes", wr_cnt[0], 14);
    fill_random(0, 8);
    run_load(0, 8, $urandom_range(0, 4), 1'b0, 1'b0, s, dc);

    // Random streams and gaps on both geometries.
    for (int r = 0; r < 3; r++) begin
      fill_random(0, 8);
      run_load(0, 8, $urandom_range(0, 5), 1'b0, 1'b0, s, dc);
      fill_random(1, 4);
      run_load(1, 4, $urandom_range(0, 5), 1'($urandom), 1'b0, s, dc);
    end

`ifdef SPRITE_LOADER_VBLANK_GATE_EN
    // vblank low for UNPACK cycles 3..10 of the first byte.
    fill_random(0, 8);
    lat_chk = 1'b0;
    run_load(0, 8, 0, 1'b0, 1'b1, s, dc);
    lat_chk = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
